// File: rtl/tri_pixel_collector.sv
// Collects rasterizer pixels into an 8x8 bitmap, then drains it row by row
// over a valid/ready handshake once the triangle's busy window closes.
module tri_pixel_collector #(
    parameter int SKIP_EMPTY_ROWS = 0,
    parameter int CNT_W           = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             busy,
    input  logic             po,
    input  logic [2:0]       xo,
    input  logic [2:0]       yo,
    output logic             in_ready,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [2:0]       row_y,
    output logic [7:0]       row_bits,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic             frame_done,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        busy_q;
    logic [63:0] bitmap;
    logic [2:0]  r;
    logic [7:0]  nz, masked;
    logic [2:0]  cur_row;
    logic        has_row, last_row, xfer, drain_end, capture, start;
    logic [5:0]  idx;

    assign idx     = {yo, xo};
    assign start   = (state == IDLE) && (busy || po);
    assign capture = po && (state != DRAIN);
    assign xfer    = row_valid && row_ready;

    // Row selection: with skipping, the current row is the lowest nonzero row at or after r.
    always_comb begin
        for (int i = 0; i < 8; i++) nz[i] = |bitmap[i*8 +: 8];
        if (SKIP_EMPTY_ROWS != 0) masked = nz & (8'hFF << r);
        else                      masked = 8'h01 << r;
        cur_row = '0;
        for (int i = 7; i >= 0; i--) if (masked[i]) cur_row = 3'(i);
        has_row = |masked;
        if (SKIP_EMPTY_ROWS != 0) last_row = (masked & ~(8'h01 << cur_row)) == 8'h00;
        else                      last_row = (r == 3'd7);
    end

    assign drain_end = (state == DRAIN) && (!has_row || (xfer && last_row));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (busy || po)      state_nxt = COLLECT;
            COLLECT: if (!busy && busy_q) state_nxt = DRAIN;
            DRAIN:   if (drain_end)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        row_valid = (state == DRAIN) && has_row;
        row_y     = row_valid ? cur_row : 3'd0;
        row_bits  = row_valid ? bitmap[{cur_row, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            bitmap     <= '0;
            r          <= '0;
            pix_cnt    <= '0;
            dup_cnt    <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            busy_q     <= busy;
            frame_done <= drain_end;
            if (start) begin
                pix_cnt <= '0;
                dup_cnt <= '0;
            end
            // Bitmap is always clear in IDLE, so a starting pixel is always new.
            if (capture) begin
                bitmap[idx] <= 1'b1;
                if (state == IDLE)  pix_cnt <= CNT_W'(1);
                else if (bitmap[idx]) dup_cnt <= (&dup_cnt) ? dup_cnt : dup_cnt + CNT_W'(1);
                else                  pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + CNT_W'(1);
            end
            if (po && state == DRAIN) ovf <= 1'b1;
            if (drain_end) begin
                bitmap <= '0;
                r      <= '0;
            end else if (state == DRAIN && xfer) begin
                r <= cur_row + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench: one collector with row skipping off (a_*) and one with it on (b_*),
// both fed from the same pixel stream.
module tb_tri_pixel_collector;

    logic       clk = 1'b0;
    logic       rst, busy, po, rdy;
    logic [2:0] xo, yo;

    logic       a_inr, a_vld, a_done, a_ovf;
    logic [2:0] a_y;
    logic [7:0] a_bits;
    logic [6:0] a_pix, a_dup;
    logic       b_inr, b_vld, b_done, b_ovf;
    logic [2:0] b_y;
    logic [7:0] b_bits;
    logic [6:0] b_pix, b_dup;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tri_pixel_collector #(.SKIP_EMPTY_ROWS(0), .CNT_W(7)) dut_a (
        .clk(clk), .reset(rst), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .in_ready(a_inr), .row_valid(a_vld), .row_ready(rdy), .row_y(a_y),
        .row_bits(a_bits), .pix_cnt(a_pix), .dup_cnt(a_dup),
        .frame_done(a_done), .ovf(a_ovf)
    );

    tri_pixel_collector #(.SKIP_EMPTY_ROWS(1), .CNT_W(7)) dut_b (
        .clk(clk), .reset(rst), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .in_ready(b_inr), .row_valid(b_vld), .row_ready(rdy), .row_y(b_y),
        .row_bits(b_bits), .pix_cnt(b_pix), .dup_cnt(b_dup),
        .frame_done(b_done), .ovf(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic last);
        po = 1'b1; xo = 3'(x); yo = 3'(y); busy = !last;
        tick();
        po = 1'b0;
    endtask

    // Walk dut_a's drain from row `start`, optionally stalling row_ready on one row.
    task automatic drain(input logic [63:0] bm, input int start, input int stall_row, input int stall_n);
        for (int r = start; r < 8; r++) begin
            if (r == stall_row) begin
                rdy = 1'b0;
                repeat (stall_n) begin
                    chk("stall_vld", a_vld, 1);
                    chk("stall_y", a_y, r);
                    chk("stall_bits", a_bits, bm[r*8 +: 8]);
                    tick();
                end
                rdy = 1'b1;
            end
            chk("row_vld", a_vld, 1);
            chk("row_y", a_y, r);
            chk("row_bits", a_bits, bm[r*8 +: 8]);
            tick();
        end
        chk("done_pulse", a_done, 1);
        chk("done_inr", a_inr, 1);
        chk("done_vld", a_vld, 0);
        tick();
        chk("done_low", a_done, 0);
        chk("inr_after", a_inr, 1);
    endtask

    initial begin
        rst = 1'b0; busy = 1'b0; po = 1'b0; rdy = 1'b1; xo = '0; yo = '0;
        tick(); tick();
        chk("rst_inr", a_inr, 1);
        chk("rst_vld", a_vld, 0);
        chk("rst_y", a_y, 0);
        chk("rst_bits", a_bits, 0);
        chk("rst_pix", a_pix, 0);
        chk("rst_dup", a_dup, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf", a_ovf, 0);
        rst = 1'b1;
        tick();

        // Reset mid-collect after three pixels
        pix(1, 1, 0); pix(2, 2, 0); pix(3, 3, 0);
        chk("mid_pix3", a_pix, 3);
        chk("mid_inr", a_inr, 0);
        rst = 1'b0;
        #1;
        chk("async_pix", a_pix, 0);
        chk("async_inr", a_inr, 1);
        chk("async_vld", a_vld, 0);
        busy = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        busy = 1'b1;
        tick();
        pix(0, 0, 1);
        chk("f1_pix", a_pix, 1);
        drain(64'h0000_0000_0000_0001, 0, -1, 0);

        // Four-pixel frame, free-running drain
        pix(1, 0, 0); pix(0, 1, 0); pix(1, 1, 0); pix(2, 1, 1);
        chk("f2_pix", a_pix, 4);
        chk("f2_dup", a_dup, 0);
        drain(64'h0000_0000_0000_0702, 0, -1, 0);

        // Same frame with a three-cycle stall on row 1
        pix(1, 0, 0); pix(0, 1, 0); pix(1, 1, 0); pix(2, 1, 1);
        drain(64'h0000_0000_0000_0702, 0, 1, 3);

        // Duplicate pixel
        pix(3, 3, 0); pix(3, 3, 1);
        chk("dup_pix", a_pix, 1);
        chk("dup_dup", a_dup, 1);
        drain(64'h0000_0000_0800_0000, 0, -1, 0);

        // Row skipping: only rows 2 and 5 come out of dut_b
        pix(7, 2, 0); pix(0, 5, 1);
        chk("skip_vld0", b_vld, 1);
        chk("skip_y0", b_y, 2);
        chk("skip_bits0", b_bits, 8'h80);
        tick();
        chk("skip_vld1", b_vld, 1);
        chk("skip_y1", b_y, 5);
        chk("skip_bits1", b_bits, 8'h01);
        tick();
        chk("skip_done", b_done, 1);
        chk("skip_vld_end", b_vld, 0);
        tick();
        chk("skip_done_low", b_done, 0);
        drain(64'h0000_0100_0080_0000, 3, -1, 0);

        // Empty frame: dut_b finishes at once, dut_a emits eight zero rows
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        chk("empty_b_vld", b_vld, 0);
        chk("empty_a_vld", a_vld, 1);
        chk("empty_a_bits", a_bits, 0);
        tick();
        chk("empty_b_done", b_done, 1);
        chk("empty_b_inr", b_inr, 1);
        drain(64'h0, 1, -1, 0);

        // Pixel injected during drain is dropped and flags overflow
        pix(1, 0, 0); pix(0, 1, 0); pix(1, 1, 0); pix(2, 1, 1);
        chk("ovf_pre", a_ovf, 0);
        chk("ovf_row0", a_bits, 8'h02);
        po = 1'b1; xo = 3'd3; yo = 3'd3;
        tick();
        po = 1'b0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_b_set", b_ovf, 1);
        chk("ovf_pix_held", a_pix, 4);
        drain(64'h0000_0000_0000_0702, 1, -1, 0);
        chk("ovf_sticky", a_ovf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_pixel_collector.md
Name: tri_pixel_collector

Overview:
Downstream stage of the triangle rasterizer. Samples the rasterizer's pixel stream (busy/po/xo/yo) and accumulates the pixels into an 8x8 bitmap. When the triangle finishes, it drains the bitmap row by row to a frame consumer over a valid/ready handshake. It also reports pixel and duplicate counts, and exposes a ready flag that the top level uses to gate nt.

Parameters:
SKIP_EMPTY_ROWS, 0, 1 = rows with no pixels are not emitted during drain; 0 = all 8 rows are emitted.
CNT_W, 7, width of pix_cnt/dup_cnt (7 bits covers the 64-pixel maximum).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
busy  input  1  rasterizer busy
po  input  1  rasterizer pixel-valid
xo  input  3  pixel x
yo  input  3  pixel y
in_ready  output  1  high = collector can take a new triangle; top level ANDs it into nt
row_valid  output  1  drained row valid
row_ready  input  1  consumer accepts row
row_y  output  3  row index of row_bits
row_bits  output  8  bit[x] = 1 if pixel (x,row_y) was produced
pix_cnt  output  CNT_W  distinct pixels in current/last frame
dup_cnt  output  CNT_W  pixels received that were already set
frame_done  output  1  one-cycle pulse after the last row is accepted
ovf  output  1  sticky: a pixel arrived while draining

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; bitmap=0; pix_cnt=0; dup_cnt=0.
  - row_valid=0; row_y=0; row_bits=0; frame_done=0; ovf=0.
  - in_ready=1.
- Inputs are sampled at each rising edge. busy_q holds the previous sampled busy.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - in_ready=1.
  - Sampled busy=1 or po=1 -> COLLECT. On that edge, clear pix_cnt/dup_cnt, and capture the pixel if po=1.
- COLLECT:
  - in_ready=0.
  - Each edge with po=1: index = yo*8+xo.
    - If the bit is clear: set it; pix_cnt+1.
    - If the bit is already set: dup_cnt+1.
    - Counters saturate at all-ones.
  - End of frame = sampled busy=0 with busy_q=1. The rasterizer drops busy on the same edge it presents the last pixel, so a po=1 on that edge is captured before leaving.
  - End of frame -> DRAIN with row pointer r=0.
- DRAIN:
  - in_ready=0.
  - Present row r: row_valid=1, row_y=r, row_bits=bitmap[r*8+:8].
    - SKIP_EMPTY_ROWS=1: zero rows are skipped combinationally, and r advances to the next nonzero row.
  - Outputs are held stable while row_valid=1 and row_ready=0.
  - Transfer on row_valid & row_ready; r advances on the same edge.
  - After the transfer of row 7, or of the last nonzero row when SKIP_EMPTY_ROWS=1:
    - row_valid=0.
    - frame_done=1 for exactly one cycle.
    - bitmap cleared.
    - -> IDLE.
  - pix_cnt/dup_cnt are held until the next COLLECT entry.
- Empty frame (busy fell with no pixels):
  - SKIP_EMPTY_ROWS=0: 8 zero rows are emitted.
  - SKIP_EMPTY_ROWS=1: no rows are emitted; frame_done pulses on the cycle after DRAIN entry.
- po=1 in DRAIN: pixel dropped, ovf=1. ovf is sticky and cleared only by reset.
- busy rising in DRAIN: ignored. IDLE is re-entered afterwards and waits for po or busy.
- reset mid-frame or mid-drain: immediate return to reset values; any partial row is discarded.
- Latency:
  - First row_valid is 1 cycle after the end-of-frame edge.
  - Drain throughput is 1 row/cycle with row_ready held 1.
  - Minimum frame_done is 9 cycles after the end-of-frame edge with SKIP_EMPTY_ROWS=0.

Test Plan:
- Reset mid-COLLECT, after 3 pixels -> all outputs return to reset values immediately. A following frame with pixel (0,0) only -> row 0 = 8'h01, pix_cnt=1.
- Frame with pixels (1,0),(0,1),(1,1),(2,1), last delivered with busy=0, row_ready=1, SKIP=0:
  - Rows y0=8'h02, y1=8'h07, y2..y7=8'h00 on consecutive cycles.
  - pix_cnt=4, dup_cnt=0.
  - frame_done pulses once, in_ready=1 the next cycle.
- Same frame with row_ready low for 3 cycles during row 1 -> row_y=1, row_bits=8'h07 held stable; no row is lost or repeated.
- Pixel (3,3) sent twice -> pix_cnt=1, dup_cnt=1, row 3 = 8'h08.
- SKIP_EMPTY_ROWS=1 with pixels (7,2) and (0,5) -> exactly two rows: (y=2, 8'h80) then (y=5, 8'h01).
- po=1 injected during DRAIN -> ovf=1 stays set; bitmap and row outputs are unaffected.
